ser_tx_framer: RTL and testbench
================================

// Module: ser_tx_framer
// PURPOSE
//  Serial frame transmitter built from the team's master-slave flop primitives.
//  Accepts a parallel word on a valid/ready handshake, then shifts it out one bit per bit period.
//  Frame: start (0), data LSB-first, optional even parity, stop (1). Line idles high.
//  Drive end of the block-to-block serial link; output feeds a pin or a downstream deserializer.
// PARAMETERS
//  DATA_W        8   data bits per frame (1..16)
//  CLKS_PER_BIT  16  clk cycles per serial bit (>=2)
//  STOP_BITS     1   stop bits per frame (1 or 2)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       reset: synchronous, active-high
//  tx_data    in   DATA_W  word to send; sampled only on accept
//  tx_valid   in   1       word offered
//  tx_ready   out  1       block can accept; high only in IDLE
//  tx_serial  out  1       serial line, registered, idle high
//  busy       out  1       frame in progress (any state except IDLE)
// BEHAVIOUR
//  - Reset (rst high at a clk edge): state=IDLE, tx_serial=1, busy=0, tx_ready=0,
//    bit counter and tick counter cleared. First cycle after rst falls: tx_ready=1.
//  - Reset mid-frame aborts the frame; line is high next cycle; no partial resume.
//  - Accept = tx_valid && tx_ready at a clk edge: tx_data is latched into the shift register,
//    and tx_ready/busy take their new values on that same edge.
//  - tx_valid while tx_ready=0 is ignored, with no queuing. tx_data changes after accept are ignored.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//    START: line 0 for CLKS_PER_BIT cycles.
//    DATA: DATA_W bits, LSB first, each held CLKS_PER_BIT cycles; shift register shifts right
//      on each bit-period tick.
//    PARITY: see CONFIGURATION.
//    STOP: line 1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
//  - Timing: tx_serial goes 0 on the edge after accept. The frame lasts exactly
//    (1+DATA_W+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 with parity and 0 without.
//    tx_ready goes to 1 on the edge that ends the last stop period.
//    Minimum gap between frames: 1 idle cycle, with the line high.
//  - Tick counter counts 0..CLKS_PER_BIT-1; terminal count advances the bit.
//    Bit counter width is $clog2(DATA_W+1). Counters hold at 0 in IDLE.
//  - tx_serial is always a flop output (no glitches). busy = (state != IDLE), registered.
// CONFIGURATION
//  SER_TX_PARITY_EN defined:
//    - PARITY state is inserted after DATA.
//    - Its bit is the even parity (XOR of the latched word), held CLKS_PER_BIT cycles.
//  SER_TX_PARITY_EN not defined:
//    - PARITY state and parity logic are absent; DATA goes directly to STOP.
// STRUCTURE
//  Package ser_tx_pkg:
//    - state enum (IDLE, START, DATA, PARITY, STOP)
//    - line levels: LINE_IDLE=1, START_BIT=0
//    - function clog2 for counter widths
//  Sub-module ser_tx_tick_gen:
//    - inputs: clk, rst, run
//    - output: one-cycle tick every CLKS_PER_BIT cycles while run=1
//    - counter cleared when run=0
//  Top holds the FSM, shift register, bit counter and parity flop.
// TESTING (DATA_W=8, CLKS_PER_BIT=4, STOP_BITS=1 unless noted)
//  1 Reset mid-frame: rst high 2 cycles during DATA -> tx_serial=1 and busy=0 the next cycle;
//    tx_ready=1 one cycle after rst falls.
//  2 Send 0xA5 -> line 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; 40 cycles total; ready back at cycle 40.
//  3 SER_TX_PARITY_EN, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; frames are 44 cycles.
//  4 tx_valid held high with 0x55 then 0xAA -> two frames separated by exactly 1 high idle cycle.
//  5 Change tx_data and pulse tx_valid during busy -> transmitted word unchanged; no extra frame.
//  6 STOP_BITS=2, CLKS_PER_BIT=2 -> stop high for 4 cycles; frame is 22 cycles.

Source files
------------

// File: rtl/ser_tx_pkg.sv
// Shared state encoding, line levels and width helper for the serial frame transmitter.
package ser_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) begin
      w++;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/ser_tx_tick_gen.sv
// Bit-period timer: tick_c pulses on the last clk of every CLKS_PER_BIT period while run is high.
module ser_tx_tick_gen
  import ser_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick_c
);

  localparam int unsigned TICK_W = clog2(CLKS_PER_BIT);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);

  logic [TICK_W-1:0] tick_cnt;

  // Counter sits at zero whenever the framer is idle so every frame starts on a clean period.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  assign tick_c = run && (tick_cnt == TICK_LAST);

endmodule

// File: rtl/ser_tx_framer.sv
// Serial frame transmitter: start bit, LSB-first data, optional even parity, stop bit(s).
// Optional parity bit enabled by defining SER_TX_PARITY_EN.
module ser_tx_framer
  import ser_tx_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_serial,
  output logic              busy
);

  localparam int unsigned BIT_CNT_W = clog2(DATA_W + 1);
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_W - 1);
  localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);

  state_t               state;
  state_t               state_next;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt_next;
  logic [DATA_W-1:0]    shreg;
  logic [DATA_W-1:0]    shreg_next;
  logic                 tx_serial_d;
  logic                 busy_d;
  logic                 tx_ready_d;
  logic                 accept_c;
  logic                 run_c;
  logic                 tick_c;

  assign accept_c = tx_valid && tx_ready;
  assign run_c    = (state != IDLE);

  ser_tx_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .run   (run_c),
    .tick_c(tick_c)
  );

`ifdef SER_TX_PARITY_EN
  logic parity_bit;

  // Even parity of the word captured at accept; later tx_data changes do not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_bit <= 1'b0;
    end else if (accept_c) begin
      parity_bit <= ^tx_data;
    end
  end
`endif

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      tx_serial <= LINE_IDLE;
      busy      <= 1'b0;
      tx_ready  <= 1'b0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      shreg     <= shreg_next;
      tx_serial <= tx_serial_d;
      busy      <= busy_d;
      tx_ready  <= tx_ready_d;
    end
  end

  // Next state; bit_cnt counts data bits in DATA and stop periods in STOP.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shreg_next   = shreg;
    case (state)
      IDLE: begin
        bit_cnt_next = '0;
        if (accept_c) begin
          state_next = START;
          shreg_next = tx_data;
        end
      end
      START: begin
        if (tick_c) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (tick_c) begin
          shreg_next = shreg >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_next = '0;
`ifdef SER_TX_PARITY_EN
            state_next   = PARITY;
`else
            state_next   = STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
          end
        end
      end
`ifdef SER_TX_PARITY_EN
      PARITY: begin
        if (tick_c) begin
          bit_cnt_next = '0;
          state_next   = STOP;
        end
      end
`endif
      STOP: begin
        if (tick_c) begin
          if (bit_cnt == STOP_LAST) begin
            bit_cnt_next = '0;
            state_next   = IDLE;
          end else begin
            bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
          end
        end
      end
      default: begin
        bit_cnt_next = '0;
        state_next   = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, taken from the next state so the pins stay flop outputs.
  always_comb begin
    tx_serial_d = LINE_IDLE;
    busy_d      = 1'b1;
    tx_ready_d  = 1'b0;
    case (state_next)
      IDLE: begin
        busy_d     = 1'b0;
        tx_ready_d = 1'b1;
      end
      START:   tx_serial_d = START_BIT;
      DATA:    tx_serial_d = shreg_next[0];
`ifdef SER_TX_PARITY_EN
      PARITY:  tx_serial_d = parity_bit;
`endif
      STOP:    tx_serial_d = LINE_IDLE;
      default: tx_serial_d = LINE_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ser_tx_framer.sv
// Directed bench for ser_tx_framer; expectations follow SER_TX_PARITY_EN when it is defined.
module tb_ser_tx_framer;

`ifdef SER_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FL  = (1 + 8 + P + 1) * 4;
  localparam int FL2 = (1 + 8 + P + 2) * 2;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_serial;
  logic       busy;
  logic [7:0] tx_data2;
  logic       tx_valid2;
  logic       tx_ready2;
  logic       tx_serial2;
  logic       busy2;

  int checks;
  int failures;

  ser_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_serial(tx_serial), .busy(busy)
  );

  ser_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(2), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx_serial(tx_serial2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    ok = (tx_ready === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (tx_serial !== 1'b1) begin failures++; $display("FAIL reset_serial got=%b exp=1", tx_serial); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", tx_ready); end
    checks++; if (tx_serial2 !== 1'b1) begin failures++; $display("FAIL reset_serial2 got=%b exp=1", tx_serial2); end
    rst = 1'b0;
    tick();
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after got=%b exp=1", tx_ready); end
    checks++; if (tx_ready2 !== 1'b1) begin failures++; $display("FAIL reset_ready2_after got=%b exp=1", tx_ready2); end
  endtask

  task automatic test_send_a5();
    bit ok;
    logic [11:0] seq;
    logic exp_b;
`ifdef SER_TX_PARITY_EN
    seq = 12'b0101_0100_1010;
`else
    seq = 12'b0011_0100_1010;
`endif
    wait_ready(ok);
    checks++; if (!ok) begin failures++; $display("FAIL a5_ready_timeout got=%b exp=1", tx_ready); end
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL a5_busy_start got=%b exp=1", busy); end
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL a5_ready_start got=%b exp=0", tx_ready); end
    for (int c = 0; c < FL; c++) begin
      exp_b = 1'(seq >> (c / 4));
      checks++; if (tx_serial !== exp_b) begin failures++; $display("FAIL a5_line cycle=%0d got=%b exp=%b", c, tx_serial, exp_b); end
      if (c == FL - 1) begin
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL a5_ready_last got=%b exp=0", tx_ready); end
      end
      tick();
    end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL a5_ready_end got=%b exp=1", tx_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL a5_busy_end got=%b exp=0", busy); end
    checks++; if (tx_serial !== 1'b1) begin failures++; $display("FAIL a5_idle_line got=%b exp=1", tx_serial); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    wait_ready(ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_ready_timeout got=%b exp=1", tx_ready); end
    tx_data = 8'h00; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    checks++; if (tx_serial !== 1'b0) begin failures++; $display("FAIL mid_data_line got=%b exp=0", tx_serial); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy); end
    rst = 1'b1;
    tick();
    checks++; if (tx_serial !== 1'b1) begin failures++; $display("FAIL mid_rst_line got=%b exp=1", tx_serial); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    tick();
    rst = 1'b0;
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got=%b exp=0", tx_ready); end
    tick();
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL mid_ready_after got=%b exp=1", tx_ready); end
    for (int c = 0; c < 6; c++) begin
      checks++; if (tx_serial !== 1'b1 || busy !== 1'b0) begin
        failures++; $display("FAIL mid_no_resume cycle=%0d got=%b/%b exp=1/0", c, tx_serial, busy);
      end
      tick();
    end
  endtask

  task automatic test_parity();
    bit ok;
    logic [7:0]  words [2];
    logic [11:0] seqs [2];
    logic exp_b;
    words[0] = 8'h07;
    words[1] = 8'h03;
`ifdef SER_TX_PARITY_EN
    seqs[0] = 12'b0110_0000_1110;
    seqs[1] = 12'b0100_0000_0110;
`else
    seqs[0] = 12'b0010_0000_1110;
    seqs[1] = 12'b0010_0000_0110;
`endif
    for (int w = 0; w < 2; w++) begin
      wait_ready(ok);
      checks++; if (!ok) begin failures++; $display("FAIL par_ready_timeout word=%0d got=%b exp=1", w, tx_ready); end
      tx_data = words[w]; tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      for (int c = 0; c < FL; c++) begin
        exp_b = 1'(seqs[w] >> (c / 4));
        checks++; if (tx_serial !== exp_b) begin
          failures++; $display("FAIL par_line word=%0d cycle=%0d got=%b exp=%b", w, c, tx_serial, exp_b);
        end
        tick();
      end
      checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL par_frame_len word=%0d got=%b exp=1", w, tx_ready); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [11:0] seq_a;
    logic [11:0] seq_b;
    logic exp_b;
`ifdef SER_TX_PARITY_EN
    seq_a = 12'b0100_1010_1010;
    seq_b = 12'b0101_0101_0100;
`else
    seq_a = 12'b0010_1010_1010;
    seq_b = 12'b0011_0101_0100;
`endif
    wait_ready(ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_ready_timeout got=%b exp=1", tx_ready); end
    tx_data = 8'h55; tx_valid = 1'b1;
    tick();
    tx_data = 8'hAA;
    for (int c = 0; c < FL; c++) begin
      exp_b = 1'(seq_a >> (c / 4));
      checks++; if (tx_serial !== exp_b) begin failures++; $display("FAIL b2b_first cycle=%0d got=%b exp=%b", c, tx_serial, exp_b); end
      tick();
    end
    checks++; if (tx_serial !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_gap got=%b/%b/%b exp=1/0/1", tx_serial, busy, tx_ready);
    end
    tick();
    tx_valid = 1'b0;
    for (int c = 0; c < FL; c++) begin
      exp_b = 1'(seq_b >> (c / 4));
      checks++; if (tx_serial !== exp_b) begin failures++; $display("FAIL b2b_second cycle=%0d got=%b exp=%b", c, tx_serial, exp_b); end
      tick();
    end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_end got=%b exp=1", tx_ready); end
  endtask

  task automatic test_ignore_busy();
    bit ok;
    logic [11:0] seq;
    logic exp_b;
`ifdef SER_TX_PARITY_EN
    seq = 12'b0100_0111_1000;
`else
    seq = 12'b0010_0111_1000;
`endif
    wait_ready(ok);
    checks++; if (!ok) begin failures++; $display("FAIL ign_ready_timeout got=%b exp=1", tx_ready); end
    tx_data = 8'h3C; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int c = 0; c < FL; c++) begin
      exp_b = 1'(seq >> (c / 4));
      checks++; if (tx_serial !== exp_b) begin failures++; $display("FAIL ign_line cycle=%0d got=%b exp=%b", c, tx_serial, exp_b); end
      if (c == 5) begin tx_data = 8'hFF; tx_valid = 1'b1; end
      if (c == 6) tx_valid = 1'b0;
      if (c == FL - 1) tx_valid = 1'b1;
      tick();
    end
    tx_valid = 1'b0;
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL ign_ready_end got=%b exp=1", tx_ready); end
    for (int c = 0; c < 6; c++) begin
      checks++; if (tx_serial !== 1'b1 || busy !== 1'b0) begin
        failures++; $display("FAIL ign_extra_frame cycle=%0d got=%b/%b exp=1/0", c, tx_serial, busy);
      end
      tick();
    end
  endtask

  task automatic test_stop_bits2();
    logic [11:0] seq;
    logic exp_b;
    int n;
`ifdef SER_TX_PARITY_EN
    seq = 12'b1101_0000_0010;
`else
    seq = 12'b0111_0000_0010;
`endif
    n = 0;
    while (tx_ready2 !== 1'b1 && n < 200) begin tick(); n++; end
    checks++; if (tx_ready2 !== 1'b1) begin failures++; $display("FAIL sb2_ready_timeout got=%b exp=1", tx_ready2); end
    tx_data2 = 8'h81; tx_valid2 = 1'b1;
    tick();
    tx_valid2 = 1'b0;
    for (int c = 0; c < FL2; c++) begin
      exp_b = 1'(seq >> (c / 2));
      checks++; if (tx_serial2 !== exp_b) begin failures++; $display("FAIL sb2_line cycle=%0d got=%b exp=%b", c, tx_serial2, exp_b); end
      if (c == FL2 - 1) begin
        checks++; if (tx_ready2 !== 1'b0 || busy2 !== 1'b1) begin
          failures++; $display("FAIL sb2_last_stop got=%b/%b exp=0/1", tx_ready2, busy2);
        end
      end
      tick();
    end
    checks++; if (tx_ready2 !== 1'b1 || busy2 !== 1'b0) begin
      failures++; $display("FAIL sb2_frame_len got=%b/%b exp=1/0", tx_ready2, busy2);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    tx_data2  = 8'h00;
    tx_valid2 = 1'b0;
    test_reset();
    test_send_a5();
    test_reset_midframe();
    test_parity();
    test_back_to_back();
    test_ignore_busy();
    test_stop_bits2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
